// File: rtl/video_timing_gen.sv
// Raster timing generator: issues pixel fetch requests ahead of the output and
// realigns the returned RGB with latency-matched sync, DE and start flags.
module video_timing_gen #(
  parameter int COLOR_WIDTH = 8,
  parameter int H_ACTIVE    = 720,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 62,
  parameter int H_BP        = 60,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 9,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 30,
  parameter int LATENCY     = 2,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  output logic                   REQ,
  output logic [HW-1:0]          REQ_X,
  output logic [VW-1:0]          REQ_Y,
  input  logic [COLOR_WIDTH-1:0] R_IN,
  input  logic [COLOR_WIDTH-1:0] G_IN,
  input  logic [COLOR_WIDTH-1:0] B_IN,
  output logic [COLOR_WIDTH-1:0] R,
  output logic [COLOR_WIDTH-1:0] G,
  output logic [COLOR_WIDTH-1:0] B,
  output logic                   HS_n,
  output logic                   VS_n,
  output logic                   DE,
  output logic                   FRAME_START,
  output logic                   LINE_START,
  output logic                   state_dbg
);

  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
  } flags_t;

  state_t        state;
  state_t        state_next;
  logic          running;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  int            h_i;
  int            v_i;
  logic          h_last;
  logic          v_last;
  logic          frame_last;

  flags_t        raw;
  flags_t        pipe [0:LATENCY];
  logic          rgb_act;

  assign h_i        = 32'(h);
  assign v_i        = 32'(v);
  assign h_last     = (h_i == H_TOTAL - 1);
  assign v_last     = (v_i == V_TOTAL - 1);
  assign frame_last = h_last && v_last;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Leaving RUN is only allowed on the last pixel of a frame so frames are never torn.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ENABLE) state_next = RUN;
      RUN:     if (frame_last && !ENABLE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    running   = (state == RUN);
    state_dbg = running;
  end

  always_ff @(posedge CLK) begin
    if (RESET || !running) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Raw per-pixel flags; all zero while idle so the delay line drains cleanly.
  always_comb begin
    raw = '0;
    if (running) begin
      raw.act = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
      raw.hs  = (h_i >= H_SYNC_BEG) && (h_i < H_SYNC_END);
      raw.vs  = (v_i >= V_SYNC_BEG) && (v_i < V_SYNC_END);
      raw.fs  = raw.act && (h_i == 0) && (v_i == 0);
      raw.ls  = raw.act && (h_i == 0);
    end
  end

  assign REQ   = raw.act;
  assign REQ_X = running ? h : '0;
  assign REQ_Y = running ? v : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i <= LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The RGB register sits one stage ahead of the flag outputs, where source data is valid.
  generate
    if (LATENCY == 0) begin : g_tap_raw
      assign rgb_act = raw.act;
    end else begin : g_tap_pipe
      assign rgb_act = pipe[LATENCY-1].act;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET || !rgb_act) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= R_IN;
      G <= G_IN;
      B <= B_IN;
    end
  end

  assign DE          = pipe[LATENCY].act;
  assign HS_n        = ~pipe[LATENCY].hs;
  assign VS_n        = ~pipe[LATENCY].vs;
  assign FRAME_START = pipe[LATENCY].fs;
  assign LINE_START  = pipe[LATENCY].ls;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed startup table, enable-drop and mid-line
// reset sequences, then random enable/reset/data against a raster-position model.
module tb_video_timing_gen;

  localparam int CW       = 8;
  localparam int H_ACTIVE = 4;
  localparam int H_FP     = 1;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 1;
  localparam int V_ACTIVE = 3;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int LAT      = 2;
  localparam int H_TOTAL  = 8;
  localparam int V_TOTAL  = 6;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  // clock / reset
  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          ENABLE = 1'b0;
  logic [CW-1:0] R_IN = '0;
  logic [CW-1:0] G_IN = '0;
  logic [CW-1:0] B_IN = '0;
  logic          REQ;
  logic [2:0]    REQ_X;
  logic [2:0]    REQ_Y;
  logic [CW-1:0] R;
  logic [CW-1:0] G;
  logic [CW-1:0] B;
  logic          HS_n;
  logic          VS_n;
  logic          DE;
  logic          FRAME_START;
  logic          LINE_START;
  logic          state_dbg;

  always #5 clk = ~clk;

  video_timing_gen #(
    .COLOR_WIDTH(CW),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .LATENCY(LAT)
  ) dut (
    .CLK(clk), .RESET(RESET), .ENABLE(ENABLE),
    .REQ(REQ), .REQ_X(REQ_X), .REQ_Y(REQ_Y),
    .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN),
    .R(R), .G(G), .B(B),
    .HS_n(HS_n), .VS_n(VS_n), .DE(DE),
    .FRAME_START(FRAME_START), .LINE_START(LINE_START),
    .state_dbg(state_dbg)
  );

  typedef struct {
    bit act;
    bit hs;
    bit vs;
    bit fs;
    bit ls;
    int x;
    int y;
  } raw_t;

  typedef struct {
    logic       req;
    logic [2:0] x;
    logic [2:0] y;
  } src_t;

  typedef struct {
    int   cyc;
    logic req;
    int   x;
    int   y;
    logic de;
    logic hs_n;
    logic vs_n;
    logic fs;
    logic ls;
    int   r;
  } vec_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  bit          m_run;
  int          m_p;
  raw_t        raw_q[$];
  logic [23:0] exp_rgb;
  src_t        src_q[$];
  bit          pattern_mode;
  vec_t        vec[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: a single linear position p within the frame, decoded into x/y.
  function automatic raw_t raw_of(input bit run, input int p);
    raw_t r;
    int   hh;
    int   vv;
    r = '{default: 0};
    hh = p % H_TOTAL;
    vv = p / H_TOTAL;
    if (run) begin
      r.act = (hh < H_ACTIVE) && (vv < V_ACTIVE);
      r.hs  = (hh >= H_ACTIVE + H_FP) && (hh < H_ACTIVE + H_FP + H_SYNC);
      r.vs  = (vv >= V_ACTIVE + V_FP) && (vv < V_ACTIVE + V_FP + V_SYNC);
      r.fs  = r.act && (p == 0);
      r.ls  = r.act && (hh == 0);
      r.x   = hh;
      r.y   = vv;
    end
    return r;
  endfunction

  task automatic model_reset();
    raw_t idle;
    idle = '{default: 0};
    m_run = 1'b0;
    m_p = 0;
    raw_q.delete();
    for (int i = 0; i <= LAT; i++) raw_q.push_back(idle);
    exp_rgb = '0;
  endtask

  // Called at a negedge: check this cycle, drive its inputs, advance the model.
  task automatic run_cycle(input logic rst, input logic en);
    raw_t       cur;
    raw_t       o;
    logic [7:0] val;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    cur = raw_of(m_run, m_p);
    o = raw_q[0];
    chk("model_req", {13'd0, state_dbg, 1'b0, REQ, 5'd0, REQ_X, 5'd0, REQ_Y},
        {13'd0, m_run, 1'b0, cur.act, 5'd0, 3'(cur.x), 5'd0, 3'(cur.y)});
    chk("model_out", {3'd0, DE, HS_n, VS_n, FRAME_START, LINE_START, R, G, B},
        {3'd0, o.act, ~o.hs, ~o.vs, o.fs, o.ls, exp_rgb});

    src_q.push_back('{req: REQ, x: REQ_X, y: REQ_Y});
    if (src_q.size() > LAT + 1) void'(src_q.pop_front());
    if (pattern_mode) begin
      if (src_q[0].req === 1'b1) begin
        val = {1'b0, src_q[0].y, 1'b0, src_q[0].x};
        r_in = val;
        g_in = ~val;
        b_in = val ^ 8'h5A;
      end else begin
        r_in = 8'hEE;
        g_in = 8'hEE;
        b_in = 8'hEE;
      end
    end else begin
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
    end
    RESET = rst;
    ENABLE = en;
    R_IN = r_in;
    G_IN = g_in;
    B_IN = b_in;

    raw_q.push_back(cur);
    if (rst) begin
      model_reset();
    end else begin
      exp_rgb = raw_q[1].act ? {r_in, g_in, b_in} : 24'd0;
      void'(raw_q.pop_front());
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1;
          m_p = 0;
        end
      end else if (m_p == FRAME - 1) begin
        m_p = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_p++;
      end
    end
    @(negedge clk);
  endtask

  task automatic add_vec(input int c, input logic req, input int x, input int y,
                         input logic de, input logic hs_n, input logic vs_n,
                         input logic fs, input logic ls, input int r);
    vec.push_back('{cyc: c, req: req, x: x, y: y, de: de, hs_n: hs_n, vs_n: vs_n,
                    fs: fs, ls: ls, r: r});
  endtask

  // Cycle 0 is the first cycle with RESET=0 and ENABLE=1.
  task automatic run_startup(input string tag);
    int k;
    int n_vs;
    int n_ls;
    int n_fs;
    int n_de;
    k = 0;
    n_vs = 0;
    n_ls = 0;
    n_fs = 0;
    n_de = 0;
    for (int c = 0; c <= 52; c++) begin
      if (VS_n === 1'b0) n_vs++;
      if (LINE_START === 1'b1) n_ls++;
      if (FRAME_START === 1'b1) n_fs++;
      if (DE === 1'b1) n_de++;
      if (k < vec.size() && vec[k].cyc == c) begin
        chk($sformatf("%s_c%0d_req", tag, c), {23'd0, REQ, 1'b0, REQ_X, 1'b0, REQ_Y},
            {23'd0, vec[k].req, 1'b0, 3'(vec[k].x), 1'b0, 3'(vec[k].y)});
        chk($sformatf("%s_c%0d_out", tag, c),
            {19'd0, DE, HS_n, VS_n, FRAME_START, LINE_START, R},
            {19'd0, vec[k].de, vec[k].hs_n, vec[k].vs_n, vec[k].fs, vec[k].ls, 8'(vec[k].r)});
        k++;
      end
      run_cycle(1'b0, 1'b1);
    end
    chk($sformatf("%s_vs_low_cycles", tag), n_vs, 8);
    chk($sformatf("%s_line_starts", tag), n_ls, 4);
    chk($sformatf("%s_frame_starts", tag), n_fs, 2);
    chk($sformatf("%s_de_cycles", tag), n_de, 13);
  endtask

  initial begin
    bit en;
    //       cyc req x y  de hs vs fs ls r
    add_vec(0,  0, 0, 0, 0, 1, 1, 0, 0, 0);
    add_vec(1,  1, 0, 0, 0, 1, 1, 0, 0, 0);
    add_vec(2,  1, 1, 0, 0, 1, 1, 0, 0, 0);
    add_vec(4,  1, 3, 0, 1, 1, 1, 1, 1, 0);
    add_vec(5,  0, 4, 0, 1, 1, 1, 0, 0, 1);
    add_vec(7,  0, 6, 0, 1, 1, 1, 0, 0, 3);
    add_vec(8,  0, 7, 0, 0, 1, 1, 0, 0, 0);
    add_vec(9,  1, 0, 1, 0, 0, 1, 0, 0, 0);
    add_vec(10, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    add_vec(11, 1, 2, 1, 0, 1, 1, 0, 0, 0);
    add_vec(12, 1, 3, 1, 1, 1, 1, 0, 1, 8'h10);
    add_vec(20, 1, 3, 2, 1, 1, 1, 0, 1, 8'h20);
    add_vec(23, 0, 6, 2, 1, 1, 1, 0, 0, 8'h23);
    add_vec(28, 0, 3, 3, 0, 1, 1, 0, 0, 0);
    add_vec(35, 0, 2, 4, 0, 1, 1, 0, 0, 0);
    add_vec(36, 0, 3, 4, 0, 1, 0, 0, 0, 0);
    add_vec(43, 0, 2, 5, 0, 1, 0, 0, 0, 0);
    add_vec(44, 0, 3, 5, 0, 1, 1, 0, 0, 0);
    add_vec(49, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(52, 1, 3, 0, 1, 1, 1, 1, 1, 0);

    pattern_mode = 1'b1;
    model_reset();
    for (int i = 0; i <= LAT; i++) src_q.push_back('{req: 1'b0, x: 3'd0, y: 3'd0});

    @(negedge clk);
    chk("reset_vals",
        {2'd0, DE, HS_n, VS_n, FRAME_START, LINE_START, REQ, REQ_X, REQ_Y, R, G, B},
        {2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 24'd0});
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_startup("startup");

    // Enable drop at cycle 10, re-enable at cycle 60
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    for (int c = 0; c <= 66; c++) begin
      case (c)
        47: chk("drop_running_c47", {25'd0, state_dbg, REQ_X, REQ_Y}, {25'd0, 1'b1, 3'd6, 3'd5});
        49: chk("drop_idle_c49", {24'd0, state_dbg, REQ, REQ_X, REQ_Y}, 32'd0);
        52: chk("drop_no_frame_c52", {30'd0, DE, FRAME_START}, 32'd0);
        55: chk("drop_idle_c55", {24'd0, state_dbg, REQ, REQ_X, REQ_Y}, 32'd0);
        61: chk("reenable_req_c61", {24'd0, state_dbg, REQ, REQ_X, REQ_Y},
                {24'd0, 1'b1, 1'b1, 3'd0, 3'd0});
        63: chk("reenable_fs_c63", {31'd0, FRAME_START}, 32'd0);
        64: chk("reenable_fs_c64", {30'd0, DE, FRAME_START}, 32'd3);
        default: ;
      endcase
      run_cycle(1'b0, (c < 10) || (c >= 60));
    end

    // Reset pulse while DE is high on line 1
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    for (int c = 0; c < 13; c++) run_cycle(1'b0, 1'b1);
    chk("midreset_de_before", {31'd0, DE}, 32'd1);
    run_cycle(1'b1, 1'b1);
    chk("midreset_after", {4'd0, DE, HS_n, VS_n, REQ, R, G, B},
        {4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0});
    run_startup("restart");

    // Random enable, rare resets, random source data
    pattern_mode = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      run_cycle(logic'($urandom_range(0, 249) == 0), en);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator and pixel output stage for the video path. It produces pixel fetch requests with coordinates ahead of time and accepts RGB data back after a fixed, parametrised source latency. It then drives a latency-aligned `VIDEO_IF`-style output: RGB at `COLOR_WIDTH`, `HS_n`, `VS_n`, plus `DE`, `FRAME_START` and `LINE_START`. It generalises the fixed 720x480 8-bit output to arbitrary timing, colour depth and source latency, with frame-boundary enable control.

## Interface
- `COLOR_WIDTH`, 8: bits per colour channel.
- `H_ACTIVE`, 720: active pixels per line.
- `H_FP`, 16: horizontal front porch, in cycles.
- `H_SYNC`, 62: horizontal sync width, in cycles.
- `H_BP`, 60: horizontal back porch, in cycles.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 9: vertical front porch, in lines.
- `V_SYNC`, 6: vertical sync width, in lines.
- `V_BP`, 30: vertical back porch, in lines.
- `LATENCY`, 2: cycles from `REQ` to valid `R_IN`/`G_IN`/`B_IN`. Range ≥ 0.
- Derived: `H_TOTAL` = sum of the H terms; `V_TOTAL` = sum of the V terms; `HW` = $clog2(H_TOTAL); `VW` = $clog2(V_TOTAL).
- One clock; reset is synchronous and active-high.
- `CLK` in 1: pixel clock.
- `RESET` in 1: synchronous, active-high.
- `ENABLE` in 1: run request.
- `REQ` out 1: pixel fetch request for (`REQ_X`, `REQ_Y`).
- `REQ_X` out HW: request column.
- `REQ_Y` out VW: request line.
- `R_IN`, `G_IN`, `B_IN` in COLOR_WIDTH each: source data, valid `LATENCY` cycles after `REQ`.
- `R`, `G`, `B` out COLOR_WIDTH each: output pixel.
- `HS_n` out 1: horizontal sync, active-low.
- `VS_n` out 1: vertical sync, active-low.
- `DE` out 1: active video.
- `FRAME_START` out 1: one-cycle pulse with pixel (0,0) at the output.
- `LINE_START` out 1: one-cycle pulse with x=0 of every active line at the output.

## Operation
- Counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1) are registered.
  - `h` wraps to 0 at H_TOTAL-1, and `v` increments on that wrap.
  - `v` wraps to 0 at V_TOTAL-1 when `h` also wraps.
- Horizontal regions, in order from `h`=0: active [0, H_ACTIVE), FP, SYNC, BP. The vertical regions use the same order and are indexed by `v`.
- Raw signals are combinational from the counters:
  - `act` = h<H_ACTIVE && v<V_ACTIVE.
  - `hs` = h inside the H SYNC region.
  - `vs` = v inside the V SYNC region, for the whole line.
- `REQ` = `act` && running. `REQ_X` = h and `REQ_Y` = v whenever running; both are 0 when idle.
- States:
  - IDLE: counters held at 0, no `REQ`.
  - RUN: counters advance every cycle.
- State transitions:
  - IDLE→RUN when `ENABLE`=1. The counter value (0,0) is presented in the first RUN cycle.
  - RUN→IDLE only at frame wrap (h=H_TOTAL-1, v=V_TOTAL-1) with `ENABLE`=0. Frames are never torn.
  - `ENABLE`=1 at frame wrap continues seamlessly into the next frame.
- Output pipeline: `act`, `hs`, `vs`, frame-start and line-start flags pass through a LATENCY+1 stage delay line.
  - The final stage drives `DE`, `HS_n` (=~hs), `VS_n` (=~vs), `FRAME_START` and `LINE_START`.
  - The stage before it samples `R_IN`/`G_IN`/`B_IN` into the `R`/`G`/`B` registers when the delayed `act`=1, otherwise loads 0.
  - Result: `R`/`G`/`B` are 0 whenever `DE`=0.
- In IDLE the delay line is fed idle values (`act`=0, hs=0, vs=0). Trailing pipeline content drains normally.

## Timing
- Reset values:
  - `DE`=0, `HS_n`=1, `VS_n`=1.
  - `R`=`G`=`B`=0.
  - `FRAME_START`=0, `LINE_START`=0.
  - `REQ`=0, `REQ_X`=0, `REQ_Y`=0.
  - State IDLE; the whole delay line is cleared.
- `RESET` overrides `ENABLE`. Reset mid-frame returns everything to reset values on the next cycle, with no drain.
- Output latency is exactly LATENCY+1 cycles from counter value to `DE`/`HS_n`/`VS_n`/`RGB`.
- A source sample presented at cycle t+LATENCY for a `REQ` at cycle t appears on `R`/`G`/`B` at cycle t+LATENCY+1.
- `LATENCY`=0: `R_IN` is sampled in the same cycle as `REQ`.
- `FRAME_START` and `LINE_START` coincide with the first `DE` cycle of their frame or line. `FRAME_START` implies `LINE_START`.
- Zero-length regions (e.g. `H_FP`=0) are legal; the adjacent regions abut.

## Test plan
Small configuration for all scenarios: `H_ACTIVE`=4, `H_FP`=1, `H_SYNC`=2, `H_BP`=1 (H_TOTAL=8); `V_ACTIVE`=3, `V_FP`=1, `V_SYNC`=1, `V_BP`=1 (V_TOTAL=6); `LATENCY`=2; `COLOR_WIDTH`=8.
- Startup: `RESET` then `ENABLE`=1 from cycle 0 -> `REQ`=1 with (0,0) at cycle 1; `DE` and `FRAME_START` both first high at cycle 4; `FRAME_START` high for 1 cycle only.
- Line: `DE` high 4 cycles, low 1, then `HS_n` low 2, high 1; period 8 cycles; `LINE_START` on each of lines 0-2 only.
- Frame: `DE` present on output lines 0-2; `VS_n` low exactly 8 consecutive cycles, starting 3 cycles after `v` reaches 4; `FRAME_START` period 48 cycles.
- Data alignment: source returns `R_IN`=16*REQ_Y+REQ_X two cycles after `REQ` -> `R` sequence 0,1,2,3 on line 0 and 0x20..0x23 on line 2; `R`=0 whenever `DE`=0.
- Enable drop: `ENABLE`=0 at cycle 10 -> counters keep running through frame wrap at cycle 48, then stay at 0 with `REQ`=0; `DE` ends after drain. `ENABLE`=1 again -> next `FRAME_START` exactly 3 cycles after the first RUN cycle.
- Reset mid-line: `RESET` pulse during `DE` on line 1 -> next cycle `DE`=0, `HS_n`=1, `VS_n`=1, `R`=`G`=`B`=0, `REQ`=0; after release, startup behaves identically to the Startup scenario.
